fifo_push_arbiter: RTL and testbench

//   Round-robin arbiter that shares one gen_fifo push port among NREQ requesters.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_push_arbiter_rr_pick.sv | 55 +++++
 rtl/fifo_push_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_arb_pkg                                                         |
// | Shared state encoding and pointer helper for fifo_push_arbiter.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Advance a round-robin pointer, wrapping nreq-1 back to 0.
  function automatic int rr_next(input int ptr, input int nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_push_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Combinational round-robin pick: rotate, priority-encode, un-rotate.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IW-1:0]     w_off;
  logic              w_hit;
  logic [IW:0]       w_sum;
  logic [IW:0]       w_wrap;

  // Rotating right by the pointer puts the highest-priority requester at bit 0.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_off = '0;
    w_hit = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IW'(k);
        w_hit = 1'b1;
      end
    end
  end

  assign w_sum  = {1'b0, i_ptr} + {1'b0, w_off};
  assign w_wrap = (w_sum >= (IW+1)'(NREQ)) ? (w_sum - (IW+1)'(NREQ)) : w_sum;

  always_comb begin
    o_any   = w_hit;
    o_idx   = '0;
    o_grant = '0;
    if (w_hit) begin
      o_idx   = w_wrap[IW-1:0];
      o_grant = NREQ'(1) << w_wrap[IW-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_push_arbiter                                                    |
// | Round-robin share of one FIFO push port among NREQ requesters.       |
// | Optional burst lock: define PUSH_ARB_LOCK_EN.                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int IW   = 2
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               flush,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_push,
  output logic [DW-1:0]      data_push,
  output logic [IW-1:0]      grant_id,
  output logic               grant_vld
);

  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   w_rr_ptr_nxt;
  logic [IW-1:0]   w_rr_inc;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;

`ifdef PUSH_ARB_LOCK_EN
  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_owner_nxt;

  // While locked only the burst owner may win; a silent owner still holds the port.
  always_comb begin
    w_elig = req_valid;
    if (r_state == ARB_LOCK) begin
      w_elig = req_valid & (NREQ'(1) << r_owner);
    end
  end
`else
  logic w_unused_last;

  assign w_unused_last = ^req_last;
  assign w_elig        = req_valid;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign grant_vld = w_any;
  assign grant_id  = w_idx;
  assign fifo_push = w_any & ~fifo_full & ~flush;
  assign req_ready = {NREQ{fifo_push}} & w_grant;

  always_comb begin
    data_push = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        data_push = req_data[DW*i +: DW];
      end
    end
  end

  assign w_rr_inc = IW'(rr_next(int'(w_idx), NREQ));

`ifdef PUSH_ARB_LOCK_EN
  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    if (flush) begin
      w_rr_ptr_nxt = '0;
      w_state_nxt  = ARB_IDLE;
      w_owner_nxt  = '0;
    end else if (fifo_push) begin
      case (r_state)
        ARB_IDLE: begin
          if (req_last[w_idx]) begin
            w_rr_ptr_nxt = w_rr_inc;
          end else begin
            w_state_nxt = ARB_LOCK;
            w_owner_nxt = w_idx;
          end
        end
        ARB_LOCK: begin
          // Pointer moves past the owner only once its burst completes.
          if (req_last[r_owner]) begin
            w_state_nxt  = ARB_IDLE;
            w_rr_ptr_nxt = w_rr_inc;
          end
        end
        default: begin
          w_state_nxt = ARB_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end
`else
  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    if (flush) begin
      w_rr_ptr_nxt = '0;
    end else if (fifo_push) begin
      w_rr_ptr_nxt = w_rr_inc;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_push_arbiter                                                 |
// | Directed vector table plus corner sequences for fifo_push_arbiter.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fifo_push_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int IW   = 2;

  logic               CLK = 1'b0;
  logic               RSTn = 1'b0;
  logic               flush = 1'b0;
  logic               fifo_full = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_last = '1;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic               fifo_push;
  logic               grant_vld;
  logic [DW-1:0]      data_push;
  logic [IW-1:0]      grant_id;

  logic [DW-1:0] rd [NREQ];
  logic [DW-1:0] cap_q[$];
  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       f;
    logic       full;
    logic [3:0] v;
    logic       vld;
    logic [1:0] id;
    logic       push;
  } vec_t;

  vec_t       vt [21];
  logic [3:0] t5_v [6];
  logic [3:0] t5_l [6];
  logic       t5_vld [6];
  logic [1:0] t5_id [6];

  int         mptr, nacc, maxwait;
  int         seq [NREQ];
  int         waitc [NREQ];
  logic [3:0] held, nv, erdy;
  logic       rf, rfu, ev, ep;
  logic [1:0] eid;
  logic [63:0] ed;

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_data[DW*i +: DW] = rd[i];
  end

  fifo_push_arbiter #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_push (fifo_push),
    .data_push (data_push),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  function automatic logic [63:0] dval(input int i, input int s);
    return {8'(8'hA0 + i), 56'(s)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Packed compare: {grant_vld, grant_id, fifo_push, req_ready, data_push}
  task automatic expect_out(input string tag, input logic vld, input logic [1:0] id, input logic push);
    logic [3:0]  rdy;
    logic [63:0] d;
    rdy = push ? (4'b0001 << id) : 4'b0000;
    d   = vld ? rd[id] : 64'd0;
    check(tag, {grant_vld, grant_id, fifo_push, req_ready, data_push}, {vld, id, push, rdy, d});
  endtask

  task automatic apply(input logic f, input logic fu, input logic [3:0] v, input logic [3:0] l);
    flush     = f;
    fifo_full = fu;
    req_valid = v;
    req_last  = l;
    #2;
  endtask

  task automatic tick();
    if (fifo_push) cap_q.push_back(data_push);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd0, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd1, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd3, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd0, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd1, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd3, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1};
    vt[10] = '{1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1};
    vt[11] = '{1'b0, 1'b0, 4'b1001, 1'b1, 2'd3, 1'b1};
    vt[12] = '{1'b0, 1'b1, 4'b0011, 1'b1, 2'd0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 4'b0011, 1'b1, 2'd0, 1'b1};
    vt[14] = '{1'b0, 1'b0, 4'b0110, 1'b1, 2'd1, 1'b1};
    vt[15] = '{1'b1, 1'b0, 4'b1001, 1'b1, 2'd3, 1'b0};
    vt[16] = '{1'b0, 1'b0, 4'b0110, 1'b1, 2'd1, 1'b1};
    vt[17] = '{1'b1, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0};
    vt[18] = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd0, 1'b1};
    vt[19] = '{1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1};
    vt[20] = '{1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};

    t5_v = '{4'b1111, 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    t5_l = '{4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b0000};
`ifdef PUSH_ARB_LOCK_EN
    t5_vld = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t5_id  = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
`else
    t5_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t5_id  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
`endif

    for (int i = 0; i < NREQ; i++) rd[i] = dval(i, 0);

    // Reset state
    apply(1'b0, 1'b0, 4'b0000, 4'b1111);
    expect_out("reset", 1'b0, 2'd0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;

    // Directed vector table
    cap_q.delete();
    for (int i = 0; i < 21; i++) begin
      apply(vt[i].f, vt[i].full, vt[i].v, 4'b1111);
      expect_out($sformatf("vec%0d", i), vt[i].vld, vt[i].id, vt[i].push);
      if (vt[i].push) exp_q.push_back(rd[vt[i].id]);
      tick();
    end
    check("fifo_count", 128'(cap_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("fifo_beat%0d", i), cap_q[i], exp_q[i]);

    // FIFO fills with alternating 0/2, then back-pressure and release
    apply(1'b1, 1'b0, 4'b0000, 4'b1111);
    tick();
    cap_q.delete();
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, (cap_q.size() >= 8), 4'b0101, 4'b1111);
      expect_out($sformatf("fill%0d", k), 1'b1, (k % 2 == 1) ? 2'd2 : 2'd0, 1'b1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, (cap_q.size() >= 8), 4'b0101, 4'b1111);
      expect_out($sformatf("full_hold%0d", k), 1'b1, 2'd0, 1'b0);
      tick();
    end
    check("pop_head", cap_q.pop_front(), rd[0]);
    apply(1'b0, (cap_q.size() >= 8), 4'b0101, 4'b1111);
    expect_out("after_pop", 1'b1, 2'd0, 1'b1);
    tick();

    // Burst from requester 1 while others compete; pointer parked at 1 first
    apply(1'b1, 1'b0, 4'b0000, 4'b1111);
    tick();
    apply(1'b0, 1'b0, 4'b0001, 4'b1111);
    expect_out("burst_pre", 1'b1, 2'd0, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b0, t5_v[k], t5_l[k]);
      expect_out($sformatf("burst%0d", k), t5_vld[k], t5_id[k], t5_vld[k]);
      tick();
    end

    // Asynchronous reset mid-cycle clears pointer and lock immediately
    apply(1'b0, 1'b0, 4'b1111, 4'b1111);
    RSTn = 1'b0;
    #1;
    expect_out("async_reset", 1'b1, 2'd0, 1'b1);
    tick();
    RSTn = 1'b1;

    // Random valids held until accepted, random full and flush
    cap_q.delete();
    nacc = 0; mptr = 0; maxwait = 0; held = '0;
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = 0;
      waitc[i] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      nv = held;
      for (int i = 0; i < NREQ; i++) begin
        if (!nv[i] && ($urandom_range(0, 1) == 1)) nv[i] = 1'b1;
        rd[i] = dval(i, seq[i]);
      end
      rf  = ($urandom_range(0, 15) == 0);
      rfu = ($urandom_range(0, 3) == 0);
      apply(rf, rfu, nv, 4'b1111);
      ev = 1'b0;
      eid = 2'd0;
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (nv[(mptr + k) % NREQ]) begin
          ev  = 1'b1;
          eid = 2'((mptr + k) % NREQ);
        end
      end
      ep   = ev & ~rfu & ~rf;
      erdy = ep ? (4'b0001 << eid) : 4'b0000;
      ed   = ev ? rd[eid] : 64'd0;
      check($sformatf("rand%0d", c), {grant_vld, grant_id, fifo_push, req_ready, data_push},
            {ev, eid, ep, erdy, ed});
      if (rf) begin
        mptr = 0;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
      end else if (ep) begin
        mptr = (int'(eid) + 1) % NREQ;
        nacc++;
        for (int i = 0; i < NREQ; i++) begin
          if (i == int'(eid)) waitc[i] = 0;
          else if (nv[i]) begin
            waitc[i]++;
            if (waitc[i] > maxwait) maxwait = waitc[i];
          end
        end
      end
      held = nv & ~req_ready;
      for (int i = 0; i < NREQ; i++) if (nv[i] && req_ready[i]) seq[i]++;
      tick();
    end
    check("rand_count", 128'(cap_q.size()), 128'(nacc));
    check("rand_fair", 128'(maxwait < NREQ), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
